// File: rtl/piso_tx_if.sv
// Handshake and serial-output bundle for piso_tx: parallel word in, LSB-first bitstream out.
interface piso_tx_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             dout;
   logic             dout_valid;
   logic             frame_start;
   logic             busy;

   modport master (
      output din, din_valid,
      input  din_ready, dout, dout_valid, frame_start, busy
   );

   modport slave (
      input  din, din_valid,
      output din_ready, dout, dout_valid, frame_start, busy
   );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: WIDTH-bit words shifted out LSB first, with a
// one-word hold register so back-to-back words produce a gap-free bitstream.
module piso_tx #(
   parameter int WIDTH = 4
) (
   input logic     clk,
   input logic     reset,
   piso_tx_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             hold_full_q, hold_full_d;
   logic             xfer;
   logic             last;

   // Ready depends only on registered state so upstream never sees a combinational loop.
   assign bus.din_ready = ~hold_full_q;
   assign xfer          = bus.din_valid & ~hold_full_q;
   assign last          = (cnt_q == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         sreg_q      <= '0;
         hold_q      <= '0;
         cnt_q       <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         hold_q      <= hold_d;
         cnt_q       <= cnt_d;
         hold_full_q <= hold_full_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      hold_d      = hold_q;
      cnt_d       = cnt_q;
      hold_full_d = hold_full_q;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               sreg_d  = bus.din;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (!last) begin
               sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
               cnt_d  = cnt_q + CW'(1);
               if (xfer) begin
                  hold_d      = bus.din;
                  hold_full_d = 1'b1;
               end
            end else if (hold_full_q) begin
               // Final bit: reload from hold first, otherwise take a word arriving right now.
               sreg_d      = hold_q;
               hold_full_d = 1'b0;
               cnt_d       = '0;
            end else if (xfer) begin
               sreg_d = bus.din;
               cnt_d  = '0;
            end else begin
               sreg_d  = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.dout        = (state_q == SHIFT) & sreg_q[0];
   assign bus.dout_valid  = (state_q == SHIFT);
   assign bus.frame_start = (state_q == SHIFT) & (cnt_q == '0);
   assign bus.busy        = (state_q == SHIFT) | hold_full_q;
endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port din, input, WIDTH bits, the parallel word to serialize.
REQ-005 SHALL have port din_valid, input, 1 bit, marking din as valid this cycle.
REQ-006 SHALL have port din_ready, output, 1 bit; the block can accept a word this cycle.
REQ-007 SHALL have port dout, output, 1 bit, the serial data bit, LSB first.
REQ-008 SHALL have port dout_valid, output, 1 bit, marking dout as a live data bit.
REQ-009 SHALL have port frame_start, output, 1 bit, high while dout carries bit 0 of a word.
REQ-010 SHALL have port busy, output, 1 bit, high when the state is SHIFT or the hold register is full.

Function
REQ-011 SHALL implement two states: IDLE (no word shifting) and SHIFT (word in shift register).
REQ-012 SHALL contain a WIDTH-bit shift register sreg, a bit counter cnt (0..WIDTH-1), and a one-word hold register with a full flag.
REQ-013 SHALL complete a transfer on a rising edge where din_valid and din_ready are both 1; din is sampled only on that edge.
REQ-014 SHALL drive din_ready = NOT hold_full, combinationally from registered state only, with no dependence on din_valid.
REQ-015 In IDLE, a transfer SHALL load din into sreg, clear cnt to 0 and enter SHIFT on the same edge, with the hold register unused.
REQ-016 In SHIFT, dout SHALL equal sreg[0], dout_valid SHALL be 1, and frame_start SHALL be 1 exactly when cnt = 0.
REQ-017 In IDLE, dout, dout_valid and frame_start SHALL all be 0.
REQ-018 On each SHIFT edge with cnt < WIDTH-1, sreg SHALL shift right by one (zero fill) and cnt SHALL increment.
REQ-019 On a SHIFT edge with cnt < WIDTH-1, a transfer SHALL write din into the hold register and set hold_full.
REQ-020 On the SHIFT edge with cnt = WIDTH-1 and hold_full = 1, the block SHALL:
- load hold into sreg;
- clear hold_full and cnt to 0;
- remain in SHIFT with no gap cycle.
REQ-021 On the SHIFT edge with cnt = WIDTH-1, hold_full = 0 and a transfer, the block SHALL load din directly into sreg, set cnt to 0 and remain in SHIFT.
REQ-022 On the SHIFT edge with cnt = WIDTH-1, hold_full = 0 and no transfer, the block SHALL return to IDLE.
REQ-023 A back-to-back word stream SHALL produce a continuous bitstream: dout_valid stays high and frame_start pulses every WIDTH cycles.
REQ-024 Latency SHALL be one cycle from the accepting edge to bit 0 on dout when in IDLE; word N SHALL occupy exactly WIDTH consecutive dout_valid cycles.
REQ-025 The bit order SHALL match the team's SIPO: after WIDTH shifts, the downstream SIPO holds the original din unchanged.

Reset
REQ-026 Asserting reset low SHALL immediately force:
- state IDLE;
- sreg, cnt, hold and hold_full to 0;
- dout, dout_valid, frame_start and busy to 0;
- din_ready to 1.
REQ-027 Reset asserted mid-word SHALL discard the partial word and any held word, with no further dout_valid.
REQ-028 After reset deasserts, the first rising edge SHALL accept a word normally.

Verification
REQ-029 Single word: WIDTH=4, din=4'b1011 accepted in IDLE -> dout = 1,1,0,1 over 4 cycles, dout_valid high for 4 cycles, frame_start only on the first, then IDLE.
REQ-030 Back-to-back: words 4'hA then 4'h5, second presented while the first shifts -> 8 contiguous valid bits 0,1,0,1,1,0,1,0 and frame_start at cycles 1 and 5.
REQ-031 Backpressure: three words offered continuously -> din_ready drops after the hold fills, and no word is lost or duplicated.
REQ-032 Last-bit direct load: hold empty, transfer of 4'hC on the cnt=3 edge -> next cycle dout=0 with frame_start=1, and no gap.
REQ-033 Reset mid-word: reset low during bit 2 of 4'hF -> dout_valid=0 at once, din_ready=1, and the next word serializes cleanly.
REQ-034 Loopback: piso_tx driving the team's 4-bit SIPO with random words -> the SIPO output equals each din one cycle after that word's last bit.
